// File: rtl/nqueen_solver_pkg.sv
// Shared types and helpers for the N-queens backtracking engine.
package nqueen_solver_pkg;

    // Controller states of the search / streaming engine
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_SAFE      = 3'd2,
        ST_NEXT_COL  = 3'd3,
        ST_BACKTRACK = 3'd4,
        ST_EMIT      = 3'd5,
        ST_FINISH    = 3'd6
    } state_e;

    // Width of a row/column index for board size n (at least one bit)
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nq_conflict.sv
// Combinational attack test between two queens: same column or same diagonal.
// Differences are formed one bit wider than the indices so they never wrap.
module nq_conflict #(
    parameter int RW = 3
) (
    input  logic [RW-1:0] row1,
    input  logic [RW-1:0] col1,
    input  logic [RW-1:0] row2,
    input  logic [RW-1:0] col2,
    output logic          conflict
);

    logic [RW:0] dcol_s;
    logic [RW:0] drow_s;

    // Absolute column and row distances, then the attack decision
    always_comb begin
        if (col1 >= col2) begin
            dcol_s = {1'b0, col1} - {1'b0, col2};
        end else begin
            dcol_s = {1'b0, col2} - {1'b0, col1};
        end
        if (row1 >= row2) begin
            drow_s = {1'b0, row1} - {1'b0, row2};
        end else begin
            drow_s = {1'b0, row2} - {1'b0, row1};
        end
        conflict = (col1 == col2) || (dcol_s == drow_s);
    end

endmodule

// File: rtl/nqueen_solver.sv
// N-queens backtracking engine. One column index is held per row; placement
// of row r is checked against one earlier row per cycle. Solutions are
// streamed row by row as one-hot words over a valid/ready handshake.
module nqueen_solver
    import nqueen_solver_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      find_all,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [N-1:0]              out_data,
    output logic [idx_width(N)-1:0]   out_row,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [CW-1:0]             sol_count
);

    localparam int RW    = idx_width(N);
    localparam int DEPTH = 2 ** RW;     // index space fully covered by RW bits
    localparam logic [RW-1:0] LAST = RW'(N - 1);

    state_e        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [RW-1:0] k_q, k_d;
    logic [RW-1:0] i_q, i_d;
    logic [RW-1:0] col_q [DEPTH];
    logic [RW-1:0] col_d [DEPTH];
    logic          fa_q, fa_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          found_q, found_d;

    logic          conflict_s;
    logic          accept_s;

    nq_conflict #(.RW(RW)) u_conflict (
        .row1     (k_q),
        .col1     (col_q[k_q]),
        .row2     (r_q),
        .col2     (col_q[r_q]),
        .conflict (conflict_s)
    );

    assign accept_s = out_valid_q && out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and search datapath update
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        i_d     = i_q;
        col_d   = col_q;
        fa_d    = fa_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fa_d     = find_all;
                    cnt_d    = '0;
                    r_d      = '0;
                    col_d[0] = '0;
                    state_d  = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (r_q == '0) begin
                    state_d = ST_SAFE;
                end else if (conflict_s) begin
                    state_d = ST_NEXT_COL;
                end else if (k_q == '0) begin
                    state_d = ST_SAFE;
                end else begin
                    k_d = k_q - RW'(1);
                end
            end
            ST_SAFE: begin
                if (r_q == LAST) begin
                    i_d     = '0;
                    state_d = ST_EMIT;
                end else begin
                    r_d                  = r_q + RW'(1);
                    col_d[r_q + RW'(1)]  = '0;
                    k_d                  = r_q;
                    state_d              = ST_CHECK;
                end
            end
            ST_NEXT_COL: begin
                if (col_q[r_q] == LAST) begin
                    state_d = ST_BACKTRACK;
                end else begin
                    col_d[r_q] = col_q[r_q] + RW'(1);
                    k_d        = r_q - RW'(1);
                    state_d    = ST_CHECK;
                end
            end
            ST_BACKTRACK: begin
                if (r_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    r_d     = r_q - RW'(1);
                    state_d = ST_NEXT_COL;
                end
            end
            ST_EMIT: begin
                if (accept_s) begin
                    if (i_q == LAST) begin
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
                        state_d = fa_q ? ST_NEXT_COL : ST_FINISH;
                    end else begin
                        i_d = i_q + RW'(1);
                    end
                end else begin
                    i_d = i_q;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_row_d   = '0;
        out_last_d  = 1'b0;
        if (state_d == ST_EMIT) begin
            out_valid_d = 1'b1;
            out_row_d   = i_d;
            out_last_d  = (i_d == LAST);
            for (int j = 0; j < N; j++) begin
                out_data_d[j] = (col_d[i_d] == RW'(j));
            end
        end else begin
            out_valid_d = 1'b0;
        end
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
        found_d = (cnt_d != '0);
    end

    // Search datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q         <= '0;
            k_q         <= '0;
            i_q         <= '0;
            fa_q        <= 1'b0;
            cnt_q       <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                col_q[j] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
        end else begin
            r_q         <= r_d;
            k_q         <= k_d;
            i_q         <= i_d;
            fa_q        <= fa_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign sol_count = cnt_q;

endmodule
